mem_access: RTL and testbench
=============================

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have parameter DM_WORDS, default 3072: data-memory depth in 32-bit words; valid byte addresses are 0 to 4*DM_WORDS-1.
REQ-002 SHALL have one clock and an asynchronous, active-high reset: `clk` input, 1 bit, rising-edge clock.
REQ-003 SHALL have `reset` input, 1 bit: asynchronous, active-high; clears all state immediately, without waiting for a `clk` edge.
REQ-004 SHALL have `valid` input, 1 bit: the EX/MEM slot holds a live instruction.
REQ-005 SHALL have `memOp` input, 4 bits: 0 none, 1 lw, 2 lh, 3 lhu, 4 lb, 5 lbu, 6 sw, 7 sh, 8 sb; codes 9-15 behave as none.
REQ-006 SHALL have `addr` input, 32 bits: byte address from the ALU.
REQ-007 SHALL have `storeData` input, 32 bits: forwarded rt value.
REQ-008 SHALL have `pc` input, 32 bits: instruction PC.
REQ-009 SHALL have `regAddr` input, 5 bits, and `regWrite` input, 1 bit: destination register and its write intent.
REQ-010 SHALL have `aluResult` input, 32 bits: writeback value for non-load instructions.
REQ-011 SHALL have `flush` input, 1 bit: synchronous bubble insertion into the MEM/WB register.
REQ-012 SHALL have `memOut` input, 32 bits: asynchronous word read data from data memory.
REQ-013 SHALL have outputs `memW` (1 bit), `memRa` (32 bits) and `memWd` (32 bits): write enable, word address and write word to data memory.
REQ-014 SHALL have registered outputs `wbValid` (1 bit), `wbRegWrite` (1 bit), `wbRegAddr` (5 bits), `wbData` (32 bits), `wbPc` (32 bits) and `wbExc` (1 bit) for the MEM/WB stage.

Function
REQ-015 SHALL drive memRa = {addr[31:2], 2'b00} combinationally at all times.
REQ-016 SHALL flag `err` when any of these holds: lw/sw with addr[1:0]≠0; lh/lhu/sh with addr[0]≠0; a load or store with addr ≥ 4*DM_WORDS.
REQ-017 SHALL assert memW only when valid=1, op is sw/sh/sb, err=0, and flush=0.
REQ-018 SHALL build memWd as read-modify-write on memOut, little-endian, byte k = bits [8k+7:8k].
REQ-019 For sw, memWd SHALL equal storeData.
REQ-020 For sh, memWd SHALL replace halfword addr[1] with storeData[15:0] and keep the other halfword of memOut.
REQ-021 For sb, memWd SHALL replace byte addr[1:0] with storeData[7:0] and keep the other bytes of memOut.
REQ-022 Load data SHALL select the addressed lane of memOut; lh/lb sign-extend, lhu/lbu zero-extend, lw passes the word unchanged.
REQ-023 On each rising clk, when flush=1 or valid=0, the MEM/WB register SHALL load all-zero (bubble).
REQ-024 On each rising clk otherwise, the register SHALL capture:
- wbValid=1, wbPc=pc, wbRegAddr=regAddr, wbExc=err;
- wbRegWrite = regWrite & ~err;
- wbData = extended load data for loads, aluResult for all other ops.
REQ-025 Latency SHALL be exactly one cycle from EX/MEM inputs to wb* outputs; the block has no stall, and it captures every cycle.
REQ-026 A load directly following a store to the same word SHALL see the stored value, since data memory commits at the same edge the store leaves.
REQ-027 When reset is asserted mid-store, memW SHALL still follow REQ-017 combinationally, and the memory's own reset governs its contents.

Reset
REQ-028 While reset=1, all wb* outputs SHALL be 0, asynchronously.
REQ-029 After reset deasserts, the first capture SHALL occur on the next rising clk.

Verification
REQ-030 The bench SHALL cover: sb addr=0x5, storeData=0xAB, memOut=0x11223344 -> memW=1, memRa=0x4, memWd=0x1122AB44.
REQ-031 The bench SHALL cover: lb addr=0x3, memOut=0x80FF0102, regWrite=1 -> next cycle wbData=0xFFFFFF80, wbRegWrite=1, wbExc=0.
REQ-032 The bench SHALL cover: lhu addr=0x2, memOut=0x9ABC0000 -> wbData=0x00009ABC.
REQ-033 The bench SHALL cover: sw addr=0x6 -> memW=0, next cycle wbExc=1, wbRegWrite=0.
REQ-034 The bench SHALL cover: lw addr=0x3000 with DM_WORDS=3072 -> wbExc=1, wbRegWrite=0.
REQ-035 The bench SHALL cover: flush=1 alongside a valid sh -> memW=0, next cycle all wb* outputs 0; reset pulsed between clk edges -> all wb* outputs 0 immediately.

Source files
------------

// File: rtl/mem_access.sv
// mem_access: MEM stage of the pipeline plus the MEM/WB pipeline register.
//
// Purpose:
//   Forms the data-memory word address. Flags misaligned and out-of-range
//   accesses. Builds the read-modify-write store word and the extended load
//   value. Registers the writeback bundle one cycle later.
//
// Ports:
//   clk, reset      rising-edge clock; asynchronous active-high reset
//   valid           EX/MEM slot holds a live instruction
//   memOp[3:0]      0 none, 1 lw, 2 lh, 3 lhu, 4 lb, 5 lbu, 6 sw, 7 sh, 8 sb (9-15 none)
//   addr[31:0]      byte address from the ALU
//   storeData[31:0] forwarded rt value
//   pc[31:0]        instruction PC
//   regAddr[4:0]    destination register
//   regWrite        destination write intent
//   aluResult[31:0] writeback value for non-load instructions
//   flush           turns this cycle's capture into a bubble
//   memOut[31:0]    asynchronous word read data from data memory
//   memW            data-memory write enable
//   memRa[31:0]     data-memory word address
//   memWd[31:0]     data-memory write word
//   wbValid, wbRegWrite, wbRegAddr[4:0], wbData[31:0], wbPc[31:0], wbExc
//                   registered MEM/WB outputs

module mem_access #(
  parameter int DM_WORDS = 3072
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  input  logic [3:0]  memOp,
  input  logic [31:0] addr,
  input  logic [31:0] storeData,
  input  logic [31:0] pc,
  input  logic [4:0]  regAddr,
  input  logic        regWrite,
  input  logic [31:0] aluResult,
  input  logic        flush,
  input  logic [31:0] memOut,
  output logic        memW,
  output logic [31:0] memRa,
  output logic [31:0] memWd,
  output logic        wbValid,
  output logic        wbRegWrite,
  output logic [4:0]  wbRegAddr,
  output logic [31:0] wbData,
  output logic [31:0] wbPc,
  output logic        wbExc
);

  localparam logic [3:0] OP_LW  = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LHU = 4'd3;
  localparam logic [3:0] OP_LB  = 4'd4;
  localparam logic [3:0] OP_LBU = 4'd5;
  localparam logic [3:0] OP_SW  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SB  = 4'd8;

  // One bit wider than the address, so a full 32-bit address compares
  // correctly against the top of memory.
  localparam logic [32:0] ADDR_LIMIT = {DM_WORDS[30:0], 2'b00};

  logic        is_load;
  logic        is_store;
  logic        err;
  logic [15:0] lane_half;
  logic [7:0]  lane_byte;
  logic [31:0] load_data;

  logic        wb_valid_d, wb_valid_q;
  logic        wb_reg_write_d, wb_reg_write_q;
  logic [4:0]  wb_reg_addr_d, wb_reg_addr_q;
  logic [31:0] wb_data_d, wb_data_q;
  logic [31:0] wb_pc_d, wb_pc_q;
  logic        wb_exc_d, wb_exc_q;

  assign memRa = {addr[31:2], 2'b00};

  always_comb begin
    is_load  = (memOp == OP_LW) || (memOp == OP_LH) || (memOp == OP_LHU) ||
               (memOp == OP_LB) || (memOp == OP_LBU);
    is_store = (memOp == OP_SW) || (memOp == OP_SH) || (memOp == OP_SB);
    err = 1'b0;
    if (((memOp == OP_LW) || (memOp == OP_SW)) && (addr[1:0] != 2'b00))
      err = 1'b1;
    if (((memOp == OP_LH) || (memOp == OP_LHU) || (memOp == OP_SH)) && addr[0])
      err = 1'b1;
    if ((is_load || is_store) && ({1'b0, addr} >= ADDR_LIMIT))
      err = 1'b1;
  end

  assign memW = valid && is_store && !err && !flush;

  // Sub-word stores merge into the word currently held in memory.
  always_comb begin
    memWd = memOut;
    case (memOp)
      OP_SW: memWd = storeData;
      OP_SH: begin
        if (addr[1]) memWd[31:16] = storeData[15:0];
        else         memWd[15:0]  = storeData[15:0];
      end
      OP_SB: begin
        case (addr[1:0])
          2'd0:    memWd[7:0]   = storeData[7:0];
          2'd1:    memWd[15:8]  = storeData[7:0];
          2'd2:    memWd[23:16] = storeData[7:0];
          default: memWd[31:24] = storeData[7:0];
        endcase
      end
      default: memWd = memOut;
    endcase
  end

  always_comb begin
    lane_half = addr[1] ? memOut[31:16] : memOut[15:0];
    case (addr[1:0])
      2'd0:    lane_byte = memOut[7:0];
      2'd1:    lane_byte = memOut[15:8];
      2'd2:    lane_byte = memOut[23:16];
      default: lane_byte = memOut[31:24];
    endcase
    case (memOp)
      OP_LH:   load_data = {{16{lane_half[15]}}, lane_half};
      OP_LHU:  load_data = {16'h0000, lane_half};
      OP_LB:   load_data = {{24{lane_byte[7]}}, lane_byte};
      OP_LBU:  load_data = {24'h000000, lane_byte};
      default: load_data = memOut;
    endcase
  end

  // Next MEM/WB contents. Both a flush and an empty slot produce an all-zero bubble.
  always_comb begin
    wb_valid_d     = 1'b0;
    wb_reg_write_d = 1'b0;
    wb_reg_addr_d  = 5'd0;
    wb_data_d      = 32'd0;
    wb_pc_d        = 32'd0;
    wb_exc_d       = 1'b0;
    if (valid && !flush) begin
      wb_valid_d     = 1'b1;
      wb_reg_write_d = regWrite && !err;
      wb_reg_addr_d  = regAddr;
      wb_data_d      = is_load ? load_data : aluResult;
      wb_pc_d        = pc;
      wb_exc_d       = err;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_valid_q     <= 1'b0;
      wb_reg_write_q <= 1'b0;
      wb_reg_addr_q  <= 5'd0;
      wb_data_q      <= 32'd0;
      wb_pc_q        <= 32'd0;
      wb_exc_q       <= 1'b0;
    end else begin
      wb_valid_q     <= wb_valid_d;
      wb_reg_write_q <= wb_reg_write_d;
      wb_reg_addr_q  <= wb_reg_addr_d;
      wb_data_q      <= wb_data_d;
      wb_pc_q        <= wb_pc_d;
      wb_exc_q       <= wb_exc_d;
    end
  end

  assign wbValid    = wb_valid_q;
  assign wbRegWrite = wb_reg_write_q;
  assign wbRegAddr  = wb_reg_addr_q;
  assign wbData     = wb_data_q;
  assign wbPc       = wb_pc_q;
  assign wbExc      = wb_exc_q;

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: self-checking bench for mem_access.
// Uses a table of hand-computed vectors and a writeback scoreboard.
// A small bench-side data memory is used for the store-then-load sequences.

module tb_mem_access;

  typedef struct packed {
    logic        valid;
    logic        rw;
    logic [4:0]  ra;
    logic [31:0] data;
    logic [31:0] pc;
    logic        exc;
  } wb_t;

  typedef struct {
    string       name;
    logic        flush;
    logic        valid;
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] sd;
    logic [31:0] mem_out;
    logic [31:0] alu;
    logic [31:0] pc;
    logic [4:0]  ra;
    logic        rw;
    logic        exp_w;
    logic [31:0] exp_ra;
    logic        chk_wd;
    logic [31:0] exp_wd;
    logic        ew_valid;
    logic        ew_rw;
    logic [4:0]  ew_ra;
    logic [31:0] ew_data;
    logic [31:0] ew_pc;
    logic        ew_exc;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        valid;
  logic [3:0]  memOp;
  logic [31:0] addr;
  logic [31:0] storeData;
  logic [31:0] pc;
  logic [4:0]  regAddr;
  logic        regWrite;
  logic [31:0] aluResult;
  logic        flush;
  logic [31:0] memOut;
  logic        memW;
  logic [31:0] memRa;
  logic [31:0] memWd;
  logic        wbValid;
  logic        wbRegWrite;
  logic [4:0]  wbRegAddr;
  logic [31:0] wbData;
  logic [31:0] wbPc;
  logic        wbExc;

  logic        mem_mode;
  logic [31:0] mem_out_drv;
  logic [31:0] bench_mem [64];

  int checks;
  int errors;

  wb_t   sb_q[$];
  string sb_name[$];
  vec_t  vecs[$];
  vec_t  mvecs[$];

  mem_access #(.DM_WORDS(3072)) dut (
    .clk(clk), .reset(reset), .valid(valid), .memOp(memOp), .addr(addr),
    .storeData(storeData), .pc(pc), .regAddr(regAddr), .regWrite(regWrite),
    .aluResult(aluResult), .flush(flush), .memOut(memOut), .memW(memW),
    .memRa(memRa), .memWd(memWd), .wbValid(wbValid), .wbRegWrite(wbRegWrite),
    .wbRegAddr(wbRegAddr), .wbData(wbData), .wbPc(wbPc), .wbExc(wbExc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Bench data memory: asynchronous read, commits on the same edge the store leaves.
  assign memOut = mem_mode ? bench_mem[memRa[7:2]] : mem_out_drv;

  always @(posedge clk) begin
    if (mem_mode && memW) bench_mem[memRa[7:2]] <= memWd;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkValue(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, got, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    flush       = v.flush;
    valid       = v.valid;
    memOp       = v.op;
    addr        = v.addr;
    storeData   = v.sd;
    mem_out_drv = v.mem_out;
    aluResult   = v.alu;
    pc          = v.pc;
    regAddr     = v.ra;
    regWrite    = v.rw;
    sb_q.push_back('{valid: v.ew_valid, rw: v.ew_rw, ra: v.ew_ra,
                     data: v.ew_data, pc: v.ew_pc, exc: v.ew_exc});
    sb_name.push_back(v.name);
  endtask

  task automatic checkOutput(input vec_t v);
    checkValue({v.name, " memW"}, {31'd0, memW}, {31'd0, v.exp_w});
    checkValue({v.name, " memRa"}, memRa, v.exp_ra);
    if (v.chk_wd) checkValue({v.name, " memWd"}, memWd, v.exp_wd);
  endtask

  task automatic checkWb();
    wb_t   exp;
    wb_t   got;
    string name;
    got = '{valid: wbValid, rw: wbRegWrite, ra: wbRegAddr, data: wbData, pc: wbPc, exc: wbExc};
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_empty: got output with no expected entry, required an entry");
    end else begin
      exp  = sb_q.pop_front();
      name = sb_name.pop_front();
      if (got !== exp) begin
        errors++;
        $display("[TB] FAIL %s wb: got v=%0b rw=%0b ra=%0d data=0x%08h pc=0x%08h exc=%0b, required v=%0b rw=%0b ra=%0d data=0x%08h pc=0x%08h exc=%0b",
                 name, got.valid, got.rw, got.ra, got.data, got.pc, got.exc,
                 exp.valid, exp.rw, exp.ra, exp.data, exp.pc, exp.exc);
      end
    end
  endtask

  task automatic checkWbZero(input string name);
    checkValue({name, " wbValid"}, {31'd0, wbValid}, 32'd0);
    checkValue({name, " wbRegWrite"}, {31'd0, wbRegWrite}, 32'd0);
    checkValue({name, " wbRegAddr"}, {27'd0, wbRegAddr}, 32'd0);
    checkValue({name, " wbData"}, wbData, 32'd0);
    checkValue({name, " wbPc"}, wbPc, 32'd0);
    checkValue({name, " wbExc"}, {31'd0, wbExc}, 32'd0);
  endtask

  task automatic runVector(input vec_t v);
    @(negedge clk);
    applyStimulus(v);
    #1;
    checkOutput(v);
    @(posedge clk);
    #1;
    checkWb();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 64; i++) bench_mem[i] = 32'd0;
    mem_mode = 1'b0; mem_out_drv = 32'd0;
    reset = 1'b1; valid = 1'b0; memOp = 4'd0; addr = 32'd0; storeData = 32'd0;
    pc = 32'd0; regAddr = 5'd0; regWrite = 1'b0; aluResult = 32'd0; flush = 1'b0;

    // Fields: name, flush, valid, op, addr, sd, memOut, alu, pc, ra, rw,
    //   expW, expRa, chkWd, expWd, then expected wb {valid, rw, ra, data, pc, exc}.
    vecs.push_back('{"sb_lane1",    0,1,4'd8,32'h5,   32'hAB,      32'h11223344,32'h5,   32'h100,5'd0, 0, 1,32'h4,   1,32'h1122AB44, 1,0,5'd0, 32'h5,       32'h100,0});
    vecs.push_back('{"lb_sign",     0,1,4'd4,32'h3,   32'h0,       32'h80FF0102,32'h3,   32'h104,5'd5, 1, 0,32'h0,   0,32'h0,        1,1,5'd5, 32'hFFFFFF80,32'h104,0});
    vecs.push_back('{"lhu_hi",      0,1,4'd3,32'h2,   32'h0,       32'h9ABC0000,32'h2,   32'h108,5'd7, 1, 0,32'h0,   0,32'h0,        1,1,5'd7, 32'h00009ABC,32'h108,0});
    vecs.push_back('{"sw_misalign", 0,1,4'd6,32'h6,   32'hDEADBEEF,32'h0,       32'h6,   32'h10C,5'd0, 1, 0,32'h4,   0,32'h0,        1,0,5'd0, 32'h6,       32'h10C,1});
    vecs.push_back('{"lw_oob",      0,1,4'd1,32'h3000,32'h0,       32'h12345678,32'h3000,32'h110,5'd9, 1, 0,32'h3000,0,32'h0,        1,0,5'd9, 32'h12345678,32'h110,1});
    vecs.push_back('{"sh_flush",    1,1,4'd7,32'h2,   32'h1111,    32'h22222222,32'h2,   32'h114,5'd4, 1, 0,32'h0,   0,32'h0,        0,0,5'd0, 32'h0,       32'h0,  0});
    vecs.push_back('{"sw_ok",       0,1,4'd6,32'h8,   32'hCAFEF00D,32'h0,       32'h8,   32'h118,5'd0, 0, 1,32'h8,   1,32'hCAFEF00D, 1,0,5'd0, 32'h8,       32'h118,0});
    vecs.push_back('{"sh_hi",       0,1,4'd7,32'h2,   32'h12345678,32'hAAAABBBB,32'h2,   32'h11C,5'd0, 0, 1,32'h0,   1,32'h5678BBBB, 1,0,5'd0, 32'h2,       32'h11C,0});
    vecs.push_back('{"sh_lo",       0,1,4'd7,32'hC,   32'h00009999,32'hAAAABBBB,32'hC,   32'h120,5'd0, 0, 1,32'hC,   1,32'hAAAA9999, 1,0,5'd0, 32'hC,       32'h120,0});
    vecs.push_back('{"lh_sign",     0,1,4'd2,32'h0,   32'h0,       32'h00018001,32'h0,   32'h124,5'd10,1, 0,32'h0,   0,32'h0,        1,1,5'd10,32'hFFFF8001,32'h124,0});
    vecs.push_back('{"lh_misalign", 0,1,4'd2,32'h1,   32'h0,       32'h00007FFF,32'h1,   32'h128,5'd11,1, 0,32'h0,   0,32'h0,        1,0,5'd11,32'h00007FFF,32'h128,1});
    vecs.push_back('{"lbu_lane1",   0,1,4'd5,32'h21,  32'h0,       32'h0000FF00,32'h21,  32'h12C,5'd12,1, 0,32'h20,  0,32'h0,        1,1,5'd12,32'h000000FF,32'h12C,0});
    vecs.push_back('{"invalid_sw",  0,0,4'd6,32'h0,   32'h77,      32'h0,       32'h0,   32'h130,5'd1, 1, 0,32'h0,   0,32'h0,        0,0,5'd0, 32'h0,       32'h0,  0});
    vecs.push_back('{"op9_none",    0,1,4'd9,32'h7,   32'h0,       32'h0,       32'h777, 32'h134,5'd13,1, 0,32'h4,   0,32'h0,        1,1,5'd13,32'h777,     32'h134,0});
    vecs.push_back('{"lw_last",     0,1,4'd1,32'h2FFC,32'h0,       32'h13579BDF,32'h2FFC,32'h138,5'd14,1, 0,32'h2FFC,0,32'h0,        1,1,5'd14,32'h13579BDF,32'h138,0});
    vecs.push_back('{"sb_oob",      0,1,4'd8,32'h3000,32'h5A,      32'h0,       32'h3000,32'h13C,5'd0, 0, 0,32'h3000,0,32'h0,        1,0,5'd0, 32'h3000,    32'h13C,1});
    vecs.push_back('{"sb_last",     0,1,4'd8,32'h2FFF,32'h5A,      32'h01020304,32'h2FFF,32'h140,5'd0, 0, 1,32'h2FFC,1,32'h5A020304, 1,0,5'd0, 32'h2FFF,    32'h140,0});
    vecs.push_back('{"lb_pos",      0,1,4'd4,32'h0,   32'h0,       32'h0000007F,32'h0,   32'h144,5'd15,1, 0,32'h0,   0,32'h0,        1,1,5'd15,32'h0000007F,32'h144,0});
    vecs.push_back('{"op0_none",    0,1,4'd0,32'h3001,32'h0,       32'h0,       32'hABC, 32'h148,5'd16,1, 0,32'h3000,0,32'h0,        1,1,5'd16,32'hABC,     32'h148,0});
    vecs.push_back('{"lb_top_addr", 0,1,4'd4,32'hFFFFFFFF,32'h0,   32'h80000000,32'h1,   32'h14C,5'd17,1, 0,32'hFFFFFFFC,0,32'h0,  1,0,5'd17,32'hFFFFFF80,32'h14C,1});

    // Back-to-back store/load pairs through the bench memory, which starts at zero.
    mvecs.push_back('{"st_sw",       0,1,4'd6,32'h10,  32'h55AA1234,32'h0,       32'h10,  32'h200,5'd0, 0, 1,32'h10,  1,32'h55AA1234, 1,0,5'd0, 32'h10,      32'h200,0});
    mvecs.push_back('{"ld_after_sw", 0,1,4'd4,32'h11,  32'h0,       32'h0,       32'h11,  32'h204,5'd2, 1, 0,32'h10,  0,32'h0,        1,1,5'd2, 32'h00000012,32'h204,0});
    mvecs.push_back('{"sh_rmw_mem",  0,1,4'd7,32'h12,  32'h0000BEEF,32'h0,       32'h12,  32'h208,5'd0, 0, 1,32'h10,  1,32'hBEEF1234, 1,0,5'd0, 32'h12,      32'h208,0});
    mvecs.push_back('{"lw_after_sh", 0,1,4'd1,32'h10,  32'h0,       32'h0,       32'h10,  32'h20C,5'd3, 1, 0,32'h10,  0,32'h0,        1,1,5'd3, 32'hBEEF1234,32'h20C,0});

    $display("[TB] reset state");
    repeat (2) @(posedge clk);
    #1;
    checkWbZero("reset_state");
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] table vectors");
    foreach (vecs[i]) runVector(vecs[i]);

    $display("[TB] store then load through bench memory");
    mem_mode = 1'b1;
    foreach (mvecs[i]) runVector(mvecs[i]);
    mem_mode = 1'b0;

    // Asynchronous reset pulsed between clock edges, with a store held on the inputs.
    $display("[TB] mid-cycle reset");
    runVector('{"pre_reset_lw", 0,1,4'd1,32'h20,32'h0,32'h00000001,32'h20,32'h500,5'd3,1, 0,32'h20,0,32'h0, 1,1,5'd3,32'h00000001,32'h500,0});
    #2;
    reset     = 1'b1;
    memOp     = 4'd6;
    addr      = 32'h40;
    storeData = 32'h9;
    aluResult = 32'h40;
    pc        = 32'h504;
    regWrite  = 1'b0;
    regAddr   = 5'd0;
    valid     = 1'b1;
    flush     = 1'b0;
    #1;
    checkWbZero("reset_async");
    checkValue("reset memW", {31'd0, memW}, 32'd1);
    checkValue("reset memRa", memRa, 32'h40);
    #1;
    reset = 1'b0;
    #1;
    checkWbZero("post_reset_hold");
    sb_q.push_back('{valid: 1'b1, rw: 1'b0, ra: 5'd0, data: 32'h40, pc: 32'h504, exc: 1'b0});
    sb_name.push_back("first_capture");
    @(posedge clk);
    #1;
    checkWb();

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries left, required 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
